// File: rtl/os_clmul_pkg.sv
// Shared types and helpers for the carry-less multiply-accumulate block.
package os_clmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // AES field polynomial x^8 + x^4 + x^3 + x + 1
  localparam logic [8:0] DEFAULT_POLY = 9'h11B;

  // Width of a W x W carry-less product
  function automatic int unsigned clmul_w(input int unsigned w);
    return 2 * w - 1;
  endfunction

endpackage

// File: rtl/os_clmul_lane.sv
// Combinational W x W carry-less (GF(2) polynomial) multiplier.
module os_clmul_lane
  import os_clmul_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0]          a,
  input  logic [W-1:0]          b,
  output logic [clmul_w(W)-1:0] prod_c
);

  // Product bit k collects every partial product a[i]&b[j] with i+j == k
  always_comb begin
    prod_c = '0;
    for (int i = 0; i < int'(W); i++) begin
      for (int j = 0; j < int'(W); j++) begin
        prod_c[i+j] = prod_c[i+j] ^ (a[i] & b[j]);
      end
    end
  end

endmodule

// File: rtl/os_clmul_acc.sv
// Multi-lane carry-less multiply-accumulate with valid/ready in and out.
// Build option: define OS_CLMUL_REDUCE_EN to reduce each beat modulo POLY.
module os_clmul_acc
  import os_clmul_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned LANES = 2,
  parameter int unsigned CNT_W = 8,
  parameter logic [W:0]  POLY  = (W+1)'(DEFAULT_POLY)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*W-1:0]    in_a,
  input  logic [LANES*W-1:0]    in_b,
  input  logic                  in_first,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [clmul_w(W)-1:0] out_data,
  output logic [CNT_W-1:0]      out_beats,
  output logic                  out_ovf
);

  localparam int unsigned PW = clmul_w(W);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state;
  logic [PW-1:0]    acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic [PW-1:0]    lane_p [LANES];
  logic [PW-1:0]    beat_c;
  logic [PW-1:0]    p_c;
  logic             accept_c;
  logic             out_hs_c;
  logic             restart_c;
  logic [PW-1:0]    acc_nx_c;
  logic [CNT_W-1:0] cnt_nx_c;
  logic             ovf_nx_c;

  for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
    os_clmul_lane #(.W(W)) u_lane (
      .a      (in_a[l*W +: W]),
      .b      (in_b[l*W +: W]),
      .prod_c (lane_p[l])
    );
  end

  always_comb begin
    beat_c = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      beat_c = beat_c ^ lane_p[l];
    end
  end

`ifdef OS_CLMUL_REDUCE_EN
  logic [PW-1:0] red_c;

  // Long division from the top bit down clears every bit at or above W
  always_comb begin
    red_c = beat_c;
    for (int k = int'(PW) - 1; k >= int'(W); k--) begin
      if (red_c[k]) begin
        red_c = red_c ^ (PW'(POLY) << (k - int'(W)));
      end
    end
    p_c = {(PW-W)'(0), red_c[W-1:0]};
  end
`else
  logic unused_poly;

  assign unused_poly = ^POLY;
  assign p_c         = beat_c;
`endif

  assign in_ready  = !out_valid | out_ready;
  assign accept_c  = in_valid & in_ready;
  assign out_hs_c  = out_valid & out_ready;
  // Outside ACC every beat opens a new accumulation; in ACC in_first restarts
  assign restart_c = in_first | (state != ST_ACC);

  always_comb begin
    acc_nx_c = acc ^ p_c;
    cnt_nx_c = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    ovf_nx_c = ovf | (cnt == CNT_MAX);
    if (restart_c) begin
      acc_nx_c = p_c;
      cnt_nx_c = CNT_W'(1);
      ovf_nx_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_beats <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (out_hs_c) begin
        out_valid <= 1'b0;
      end
      if (accept_c) begin
        acc <= acc_nx_c;
        cnt <= cnt_nx_c;
        ovf <= ovf_nx_c;
        if (in_last) begin
          state     <= ST_HOLD;
          out_valid <= 1'b1;
          out_data  <= acc_nx_c;
          out_beats <= cnt_nx_c;
          out_ovf   <= ovf_nx_c;
        end else begin
          state <= ST_ACC;
        end
      end else if (out_hs_c) begin
        state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_os_clmul_acc.sv
// Randomized self-checking bench for os_clmul_acc against a GF(2) reference model.
module tb_os_clmul_acc;

  localparam int W     = 8;
  localparam int LANES = 2;
  localparam int PW    = 2 * W - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_first;
  logic               in_last;
  logic [LANES*W-1:0] in_a;
  logic [LANES*W-1:0] in_b;
  logic               out_ready;

  logic               in_ready;
  logic               out_valid;
  logic [PW-1:0]      out_data;
  logic [7:0]         out_beats;
  logic               out_ovf;

  logic               sat_in_ready;
  logic               sat_out_valid;
  logic [PW-1:0]      sat_out_data;
  logic [1:0]         sat_out_beats;
  logic               sat_out_ovf;

  int checks = 0;
  int errors = 0;

  // Reference state: running sum, unsaturated beat count, open accumulation
  logic [PW-1:0] m_acc;
  int            m_cnt;
  bit            m_active;

  always #5 clk = ~clk;

  os_clmul_acc #(.W(W), .LANES(LANES), .CNT_W(8)) dut (
    .clk, .rst, .in_valid, .in_ready, .in_a, .in_b, .in_first, .in_last,
    .out_valid, .out_ready, .out_data, .out_beats, .out_ovf
  );

  os_clmul_acc #(.W(W), .LANES(LANES), .CNT_W(2)) dut_sat (
    .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (sat_in_ready),
    .in_a (in_a), .in_b (in_b), .in_first (in_first), .in_last (in_last),
    .out_valid (sat_out_valid), .out_ready (out_ready), .out_data (sat_out_data),
    .out_beats (sat_out_beats), .out_ovf (sat_out_ovf)
  );

  // Polynomial product as XOR of shifted copies of a
  function automatic logic [PW-1:0] ref_clmul(input logic [7:0] a, input logic [7:0] b);
    logic [PW-1:0] r = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) r = r ^ (PW'(a) << i);
    return r;
  endfunction

  // GF(2^8) multiply by the shift-and-xtime method
  function automatic logic [PW-1:0] ref_gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in;
    logic [7:0] b = b_in;
    logic [7:0] p = 8'h00;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1B;
      b  = b >> 1;
    end
    return PW'(p);
  endfunction

  function automatic logic [PW-1:0] ref_beat(input logic [15:0] a, input logic [15:0] b);
    logic [PW-1:0] r = '0;
    for (int l = 0; l < LANES; l++) begin
`ifdef OS_CLMUL_REDUCE_EN
      r = r ^ ref_gmul(a[l*8 +: 8], b[l*8 +: 8]);
`else
      r = r ^ ref_clmul(a[l*8 +: 8], b[l*8 +: 8]);
`endif
    end
    return r;
  endfunction

  function automatic logic [7:0] exp_beats(input int c);
    return 8'((c > 255) ? 255 : c);
  endfunction

  function automatic logic [1:0] exp_sat_beats(input int c);
    return 2'((c > 3) ? 3 : c);
  endfunction

  // Present one beat (assumed ready), then advance the reference model
  task automatic send_beat(input logic [15:0] a, input logic [15:0] b,
                           input logic first, input logic last);
    logic [PW-1:0] p;
    in_a = a; in_b = b; in_first = first; in_last = last; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    p = ref_beat(a, b);
    if (first || !m_active) begin
      m_acc = p;
      m_cnt = 1;
    end else begin
      m_acc = m_acc ^ p;
      m_cnt++;
    end
    m_active = !last;
  endtask

  task automatic idle_cycle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_active = 0; m_acc = '0; m_cnt = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (out_beats !== 8'd0) begin errors++; $display("FAIL reset_out_beats got %0d want 0", out_beats); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf got %b want 0", out_ovf); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    send_beat({8'h00, 8'h03}, {8'h00, 8'h03}, 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", out_valid); end
    checks++; if (out_data !== 15'h0005) begin errors++; $display("FAIL single_data got %h want 0005", out_data); end
    checks++; if (out_beats !== 8'd1) begin errors++; $display("FAIL single_beats got %0d want 1", out_beats); end
    idle_cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", out_valid); end
  endtask

  task automatic test_product();
    logic [PW-1:0] want;
`ifdef OS_CLMUL_REDUCE_EN
    want = 15'h0001;
`else
    want = 15'h3F7E;
`endif
    send_beat({8'h00, 8'h53}, {8'h00, 8'hCA}, 1'b1, 1'b1);
    checks++; if (out_data !== want) begin errors++; $display("FAIL product_data got %h want %h", out_data, want); end
    checks++; if (out_data !== m_acc) begin errors++; $display("FAIL product_model got %h want %h", out_data, m_acc); end
    idle_cycle();
  endtask

  task automatic test_cancel();
    send_beat(16'hFFFF, 16'h0101, 1'b1, 1'b0);
    send_beat(16'hFFFF, 16'h0101, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL cancel_midvalid got %b want 0", out_valid); end
    send_beat(16'hFFFF, 16'h0101, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL cancel_valid got %b want 1", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL cancel_data got %h want 0", out_data); end
    checks++; if (out_beats !== 8'd3) begin errors++; $display("FAIL cancel_beats got %0d want 3", out_beats); end
    idle_cycle();
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] held;
    out_ready = 1'b0;
    send_beat(16'($urandom), 16'($urandom), 1'b1, 1'b1);
    held = m_acc;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b want 0", c, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_data !== held) begin
        errors++; $display("FAIL bp_hold cyc %0d got v=%b d=%h want v=1 d=%h", c, out_valid, out_data, held);
      end
    end
    out_ready = 1'b1;
    send_beat(16'($urandom), 16'($urandom), 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_nogap_valid got %b want 1", out_valid); end
    checks++; if (out_data !== m_acc) begin errors++; $display("FAIL bp_nogap_data got %h want %h", out_data, m_acc); end
    checks++; if (out_beats !== 8'd1) begin errors++; $display("FAIL bp_nogap_beats got %0d want 1", out_beats); end
    idle_cycle();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++)
      send_beat(16'($urandom), 16'($urandom), i == 0, i == 4);
    checks++; if (sat_out_beats !== 2'd3) begin errors++; $display("FAIL sat_beats got %0d want 3", sat_out_beats); end
    checks++; if (sat_out_ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf got %b want 1", sat_out_ovf); end
    checks++; if (out_beats !== 8'd5 || out_ovf !== 1'b0) begin
      errors++; $display("FAIL sat_wide got %0d/%b want 5/0", out_beats, out_ovf);
    end
    checks++; if (sat_out_data !== m_acc) begin errors++; $display("FAIL sat_data got %h want %h", sat_out_data, m_acc); end
    idle_cycle();
  endtask

  task automatic test_restart();
    logic [15:0]   a [5];
    logic [15:0]   b [5];
    logic [PW-1:0] want;
    for (int i = 0; i < 5; i++) begin a[i] = 16'($urandom); b[i] = 16'($urandom); end
    send_beat(a[0], b[0], 1'b1, 1'b0);
    send_beat(a[1], b[1], 1'b0, 1'b0);
    send_beat(a[2], b[2], 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL restart_novalid got %b want 0", out_valid); end
    send_beat(a[3], b[3], 1'b0, 1'b0);
    send_beat(a[4], b[4], 1'b0, 1'b1);
    want = ref_beat(a[2], b[2]) ^ ref_beat(a[3], b[3]) ^ ref_beat(a[4], b[4]);
    checks++; if (out_data !== want) begin errors++; $display("FAIL restart_data got %h want %h", out_data, want); end
    checks++; if (out_beats !== 8'd3) begin errors++; $display("FAIL restart_beats got %0d want 3", out_beats); end
    idle_cycle();
  endtask

  task automatic test_reset_recovery();
    logic [15:0] a;
    logic [15:0] b;
    send_beat(16'($urandom), 16'($urandom), 1'b1, 1'b0);
    send_beat(16'($urandom), 16'($urandom), 1'b0, 1'b0);
    rst = 1'b1;
    in_a = 16'($urandom); in_b = 16'($urandom); in_last = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    m_active = 0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstrec_valid cyc %0d got %b want 0", c, out_valid); end
      @(posedge clk); #1;
    end
    a = 16'($urandom); b = 16'($urandom);
    send_beat(a, b, 1'b0, 1'b1);
    checks++; if (out_data !== ref_beat(a, b)) begin
      errors++; $display("FAIL rstrec_data got %h want %h", out_data, ref_beat(a, b));
    end
    checks++; if (out_beats !== 8'd1) begin errors++; $display("FAIL rstrec_beats got %0d want 1", out_beats); end
    idle_cycle();
  endtask

  // Back-to-back random accumulations with occasional mid-stream restarts
  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      int len;
      len = int'($urandom_range(1, 6));
      for (int i = 0; i < len; i++) begin
        logic first;
        first = (i == 0) ? 1'($urandom) : ($urandom_range(0, 5) == 0);
        send_beat(16'($urandom), 16'($urandom), first, i == len - 1);
        if (i != len - 1) begin
          checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_mid t%0d got %b want 0", t, out_valid); end
        end
      end
      checks++; if (out_valid !== 1'b1 || out_data !== m_acc) begin
        errors++; $display("FAIL b2b_data t%0d got v=%b d=%h want v=1 d=%h", t, out_valid, out_data, m_acc);
      end
      checks++; if (out_beats !== exp_beats(m_cnt) || out_ovf !== (m_cnt > 255)) begin
        errors++; $display("FAIL b2b_beats t%0d got %0d/%b want %0d", t, out_beats, out_ovf, m_cnt);
      end
      checks++; if (sat_out_beats !== exp_sat_beats(m_cnt) || sat_out_ovf !== (m_cnt > 3)) begin
        errors++; $display("FAIL b2b_sat t%0d got %0d/%b want %0d/%b", t, sat_out_beats, sat_out_ovf,
                           exp_sat_beats(m_cnt), m_cnt > 3);
      end
    end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_product();
    test_cancel();
    test_backpressure();
    test_saturation();
    test_restart();
    test_reset_recovery();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
